// File: rtl/undither_2x2.sv
// Purpose: rebuild an 8-bit channel from a 4-bit 2x2-dithered raster by averaging the current/previous-line 2x2 window.
// Latency: 2 clk from an accepted in_valid pixel to out_valid; sof/eol travel with their pixel.
// Backpressure: none; the stream is accepted every cycle in_valid is high, and gaps are allowed.
module undither_2x2 #(
    parameter int H_ACTIVE = 640,
    parameter int X_W      = $clog2(H_ACTIVE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bypass,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic       in_sof,
    input  logic       in_eol,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eol,
    output logic       line_err
);

    // One extra counter bit, so an overlong line is seen as x == H_ACTIVE rather than wrapping.
    localparam int XC_W = X_W + 1;
    localparam logic [XC_W-1:0] X_MAX  = XC_W'(H_ACTIVE);
    localparam logic [XC_W-1:0] X_LAST = XC_W'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIRST_LINE = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XC_W-1:0] x, x_nxt, x_eff;
    logic            err_nxt;
    logic            accept, in_rng, wr_en, first_line;

    // Line buffer (previous line) and its registered read port.
    logic [3:0]      mem [H_ACTIVE];
    logic [3:0]      rd_q;

    // Stage 1 pixel and flags.
    logic            s1_vld, s1_sof, s1_eol, s1_first, s1_left, s1_byp;
    logic [3:0]      s1_a;

    // Left-neighbour history: last A and last effective C, updated only on real pixels.
    logic [3:0]      prev_a, prev_c;

    // Stage 2 window.
    logic [3:0]      c_eff, b_eff, d_eff;
    logic [5:0]      sum;
    logic [7:0]      avg;

    // Frame/line control: acceptance, state, column counter and error flag.
    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        err_nxt    = line_err;
        accept     = in_valid & (in_sof | (state != IDLE));
        x_eff      = in_sof ? '0 : x;
        in_rng     = (x_eff < X_MAX);
        wr_en      = accept & in_rng;
        first_line = in_sof | (state == FIRST_LINE);
        if (accept) begin
            // A start-of-frame acts first, then any end-of-line on the same pixel.
            if (in_sof) begin
                state_nxt = in_eol ? ACTIVE : FIRST_LINE;
            end else if ((state == FIRST_LINE) && in_eol) begin
                state_nxt = ACTIVE;
            end
            if (in_eol) begin
                x_nxt = '0;
            end else if (in_rng) begin
                x_nxt = x_eff + XC_W'(1);
            end else begin
                x_nxt = x_eff;
            end
            err_nxt = (in_sof ? 1'b0 : line_err) | ~in_rng | (in_eol & (x_eff != X_LAST));
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            line_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            line_err <= err_nxt;
        end
    end

    // Read-first line buffer; contents are never reset, and the top-edge replicate masks them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rd_q                <= mem[x_eff[X_W-1:0]];
            mem[x_eff[X_W-1:0]] <= in_data;
        end
    end

    // Stage 1: capture the current pixel and its flags alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_first <= 1'b0;
            s1_left  <= 1'b0;
            s1_byp   <= 1'b0;
        end else begin
            s1_vld <= wr_en;
            if (wr_en) begin
                s1_a     <= in_data;
                s1_sof   <= in_sof;
                s1_eol   <= in_eol;
                s1_first <= first_line;
                s1_left  <= (x_eff == '0);
                s1_byp   <= bypass;
            end
        end
    end

    // Stage 2 window with edge replication, and sum*17/4 scaling (0 -> 0, 60 -> 255).
    always_comb begin
        c_eff = s1_first ? s1_a : rd_q;
        b_eff = s1_left ? s1_a : prev_a;
        d_eff = s1_left ? c_eff : prev_c;
        sum   = {2'b00, s1_a} + {2'b00, b_eff} + {2'b00, c_eff} + {2'b00, d_eff};
        avg   = 8'(({sum, 4'b0000} + {4'b0000, sum}) >> 2);
    end

    // Stage 2: output register and neighbour history; bypass only changes the output value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            prev_a    <= '0;
            prev_c    <= '0;
        end else begin
            out_valid <= s1_vld;
            out_sof   <= s1_vld & s1_sof;
            out_eol   <= s1_vld & s1_eol;
            if (s1_vld) begin
                out_data <= s1_byp ? {s1_a, s1_a} : avg;
                prev_a   <= s1_a;
                prev_c   <= c_eff;
            end
        end
    end

endmodule
